mips_ctrl_fsm: RTL
==================

Name: mips_ctrl_fsm

Overview:
Multi-cycle control sequencer for the 8-bit MIPS core: it steps the shared ALU, register file and data memory through fetch, decode, execute, memory and writeback, issuing one-hot-in-time strobes to the datapath. It consumes the 8-bit Instruction word returned by IMEM for the current PC, handshakes with data memory, and exposes a retired-instruction counter for the LED display path.

Parameters:
MEM_TIMEOUT, 15, max cycles S_MEM waits for mem_ack before faulting (1..255)
CNT_W, 7, width of retired-instruction counter (drives LED)

Ports:
Clk_O  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
Instruction  input  8  IMEM word at current PC; op = Instruction[7:6] (00 add, 01 lw, 10 sw, 11 j)
mem_ack  input  1  data memory done (one cycle pulse or level)
ir_we  output  1  latch Instruction into IR
pc_we  output  1  update PC
pc_src  output  1  0 = PC+1, 1 = jump target
reg_we  output  1  register file write
reg_dst  output  1  0 = rt, 1 = rd destination
mem_to_reg  output  1  writeback source: 0 ALU, 1 memory
alu_src  output  1  0 = rt data, 1 = sign-extended imm
mem_req  output  1  data memory request, held until ack
mem_we  output  1  data memory write qualifier (valid with mem_req)
fault  output  1  sticky memory-timeout flag
retired  output  CNT_W  retired-instruction count
state_o  output  3  current state encoding (debug)

Behaviour:
- States (3-bit): S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEM=3, S_WB=4, S_HALT=7.
- Reset (sampled at edge): state->S_FETCH, retired->0, fault->0, timeout counter->0, latched op->00. While Reset is high all strobes are forced to 0.
- Strobes are Moore decode of state plus latched op (op captured when ir_we=1).
- S_FETCH: ir_we=1, pc_we=1, pc_src=0 -> S_DECODE.
- S_DECODE: op=11: pc_we=1, pc_src=1, retired++ -> S_FETCH. Otherwise -> S_EXEC.
- S_EXEC: add: alu_src=0; lw/sw: alu_src=1. add -> S_WB; lw/sw -> S_MEM.
- S_MEM: mem_req=1, mem_we=(op==10), alu_src=1. Stay until mem_ack is sampled high. Then lw -> S_WB; sw: retired++ -> S_FETCH. Timeout counter increments each waiting cycle. If the count reaches MEM_TIMEOUT without ack: fault<=1 -> S_HALT. An ack on the same cycle the count reaches MEM_TIMEOUT wins (no fault).
- S_WB: reg_we=1, reg_dst=(op==00), mem_to_reg=(op==01), retired++ -> S_FETCH.
- S_HALT: all strobes 0. Exits only via Reset.
- Latency: j=2, add=4, sw=4+wait, lw=5+wait cycles.
- retired wraps modulo 2^CNT_W (127->0 for default).
- mem_ack outside S_MEM is ignored.
- Reset mid-instruction: the next cycle is S_FETCH with no partial writeback.
- Unused state encodings 5 and 6 -> S_FETCH.

Optional Feature:
MIPS_SINGLE_STEP_EN:
- Defined: adds input ports step (1) and run (1). With run=0, S_FETCH is entered only after a rising edge of step (edge detect registered internally); all strobes are 0 while waiting. run=1 behaves as free-running.
- Undefined: ports are absent and the FSM always free-runs.

Decomposition:
- Package mips_pkg: opcode constants (OP_ADD, OP_LW, OP_SW, OP_J), state encodings, and the state typedef. These are shared with the datapath and bench.
- Sub-module mips_mem_timer: loadable down-counter with a timeout flag, used by S_MEM.
- All other logic is one FSM module.

Test Plan:
- Reset held 3 cycles, then release with Instruction=8'h00 (add) -> strobes 0 during Reset; state sequence 0,1,2,4,0; reg_we=1 with reg_dst=1 only in S_WB; retired=1 after 4 cycles.
- Instruction=8'hC5 (j) -> pc_we=1 in both S_FETCH (pc_src=0) and S_DECODE (pc_src=1); back to S_FETCH after 2 cycles; retired increments by 1.
- lw (8'h46) with mem_ack delayed 3 cycles -> mem_req high for 4 cycles with mem_we=0; then S_WB with mem_to_reg=1, reg_dst=0; total 8 cycles.
- sw (8'h8A) with immediate ack -> mem_req=mem_we=1 for 1 cycle; no reg_we; 4 cycles total.
- lw with mem_ack never asserted -> fault=1 after MEM_TIMEOUT=15 wait cycles; state_o=7 held; ack at cycle 15 instead -> no fault.
- Reset asserted in S_MEM -> no reg_we follows; next state S_FETCH. 130 add instructions -> retired wraps and reads 2.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the 8-bit MIPS control path: opcode field values
// and the control sequencer's state encodings. Used by the datapath and bench.
package mips_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    // Encodings 5 and 6 are unused and recover to S_FETCH.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

endpackage

// File: rtl/mips_ctrl_fsm_if.sv
// Control bundle between the sequencer and the datapath/memory side.
// master = sequencer (drives strobes and status), slave = datapath side.
interface mips_ctrl_fsm_if #(
    parameter int CNT_W = 7
);
    logic [7:0]       Instruction;
    logic             mem_ack;
    logic             ir_we;
    logic             pc_we;
    logic             pc_src;
    logic             reg_we;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src;
    logic             mem_req;
    logic             mem_we;
    logic             fault;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state_o;

    modport master (
        input  Instruction, mem_ack,
        output ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg, alu_src,
               mem_req, mem_we, fault, retired, state_o
    );

    modport slave (
        output Instruction, mem_ack,
        input  ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg, alu_src,
               mem_req, mem_we, fault, retired, state_o
    );
endinterface

// File: rtl/mips_mem_timer.sv
// Loadable down-counter bounding how long S_MEM waits for mem_ack.
// Loaded with MEM_TIMEOUT before the wait; expire flags the last allowed
// waiting cycle so the sequencer can fault on that same cycle.
module mips_mem_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic Clk_O,
    input  logic Reset,
    input  logic load,
    input  logic tick,
    output logic expire
);
    logic [7:0] cnt;

    // Count down one per waiting cycle; hold at zero.
    always_ff @(posedge Clk_O) begin
        if (Reset) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= 8'(MEM_TIMEOUT);
        end else if (tick && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign expire = (cnt == 8'd1);
endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle control sequencer for the 8-bit MIPS core:
// fetch -> decode -> exec -> (mem) -> (writeback), with a memory timeout
// that latches a sticky fault and halts until Reset.
// Optional build macro: MIPS_SINGLE_STEP_EN adds step/run inputs that gate
// each instruction fetch on a rising edge of step while run is low.
module mips_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int          CNT_W       = 7
) (
    input  logic Clk_O,
    input  logic Reset,
`ifdef MIPS_SINGLE_STEP_EN
    input  logic step,
    input  logic run,
`endif
    mips_ctrl_fsm_if.master bus
);
    state_t           state;
    logic [1:0]       op;
    logic [CNT_W-1:0] retired_q;
    logic             fault_q;
    logic             go;
    logic             expire;

`ifdef MIPS_SINGLE_STEP_EN
    logic step_d;
    logic step_pending;

    // Register step, remember a rising edge until the fetch it releases.
    always_ff @(posedge Clk_O) begin
        if (Reset) begin
            step_d       <= 1'b0;
            step_pending <= 1'b0;
        end else begin
            step_d <= step;
            if (state == S_FETCH && go) begin
                step_pending <= 1'b0;
            end else if (step && !step_d) begin
                step_pending <= 1'b1;
            end
        end
    end

    assign go = run | step_pending;
`else
    assign go = 1'b1;
`endif

    mips_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .Clk_O  (Clk_O),
        .Reset  (Reset),
        .load   (state == S_EXEC),
        .tick   (state == S_MEM && !bus.mem_ack),
        .expire (expire)
    );

    // State, latched opcode, retired counter and sticky fault.
    always_ff @(posedge Clk_O) begin
        // NOTE: non-blocking assignments so every register here samples
        // the pre-edge values of state/op regardless of statement order.
        if (Reset) begin
            state     <= S_FETCH;
            op        <= OP_ADD;
            retired_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (go) begin
                        op    <= bus.Instruction[7:6];
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (op == OP_J) begin
                        retired_q <= retired_q + CNT_W'(1);
                        state     <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= (op == OP_ADD) ? S_WB : S_MEM;
                end
                S_MEM: begin
                    // A late ack on the expiring cycle still completes.
                    if (bus.mem_ack) begin
                        if (op == OP_LW) begin
                            state <= S_WB;
                        end else begin
                            retired_q <= retired_q + CNT_W'(1);
                            state     <= S_FETCH;
                        end
                    end else if (expire) begin
                        fault_q <= 1'b1;
                        state   <= S_HALT;
                    end
                end
                S_WB: begin
                    retired_q <= retired_q + CNT_W'(1);
                    state     <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Moore strobe decode from state and latched opcode, silenced in Reset.
    always_comb begin
        // NOTE: every strobe gets a default first so no path infers a latch.
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_src     = 1'b0;
        bus.reg_we     = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src    = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        if (!Reset) begin
            case (state)
                S_FETCH: begin
                    bus.ir_we = go;
                    bus.pc_we = go;
                end
                S_DECODE: begin
                    bus.pc_we  = (op == OP_J);
                    bus.pc_src = (op == OP_J);
                end
                S_EXEC: begin
                    bus.alu_src = (op != OP_ADD);
                end
                S_MEM: begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = (op == OP_SW);
                    bus.alu_src = 1'b1;
                end
                S_WB: begin
                    bus.reg_we     = 1'b1;
                    bus.reg_dst    = (op == OP_ADD);
                    bus.mem_to_reg = (op == OP_LW);
                end
                default: ;
            endcase
        end
    end

    assign bus.fault   = fault_q;
    assign bus.retired = retired_q;
    assign bus.state_o = state;
endmodule
